// File: rtl/led_matrix_pkg.sv
// ---------------------------------------------------------------------------
// led_matrix_pkg
// Shared types and helpers for the LED matrix scan controller.
//   BTN_N         number of button pads
//   btn_code_t    3-bit chord code
//   chord_encode  maps a stable active-low pad vector to a chord code
// ---------------------------------------------------------------------------
package led_matrix_pkg;

    localparam int BTN_N = 5;

    typedef logic [2:0] btn_code_t;

    // Only the eight listed chords are legal; anything else reports valid=0.
    function automatic void chord_encode(input  logic [BTN_N-1:0] btn_n,
                                         output logic             valid,
                                         output btn_code_t        code);
        valid = 1'b1;
        code  = 3'd0;
        case (btn_n)
            5'b11111: code = 3'd0;
            5'b11100: code = 3'd1;
            5'b11010: code = 3'd2;
            5'b10110: code = 3'd3;
            5'b11001: code = 3'd4;
            5'b10101: code = 3'd5;
            5'b10011: code = 3'd6;
            5'b01111: code = 3'd7;
            default:  valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/led_matrix_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_matrix_scan_ctrl_if
// Bundles the MCU/button side inputs and the status/drive outputs of the
// scan controller.
//   master : MCU/button side (drives row_clk, row_data, row_latch, btn_n)
//   slave  : the controller (drives row_out, col_idx, col_adv, btn_code,
//            btn_valid)
// ---------------------------------------------------------------------------
interface led_matrix_scan_ctrl_if
    import led_matrix_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int COLS = 16
);
    logic                    row_clk;
    logic                    row_data;
    logic                    row_latch;
    logic [BTN_N-1:0]        btn_n;
    logic [ROWS-1:0]         row_out;
    logic [$clog2(COLS)-1:0] col_idx;
    logic                    col_adv;
    btn_code_t               btn_code;
    logic                    btn_valid;

    modport master (
        output row_clk, row_data, row_latch, btn_n,
        input  row_out, col_idx, col_adv, btn_code, btn_valid
    );

    modport slave (
        input  row_clk, row_data, row_latch, btn_n,
        output row_out, col_idx, col_adv, btn_code, btn_valid
    );
endinterface

// File: rtl/led_matrix_scan_ctrl_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for one asynchronous bit.
//   clk, rst  system clock, synchronous active-high reset
//   i_d       asynchronous input
//   o_q       synchronised output (RST_VAL while in reset)
// ---------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// led_matrix_scan_ctrl
// Row shift-in with double buffering, free-running open-drain column scan,
// and a debounced 5-pad chord encoder.
//   clk      system clock
//   rst      synchronous active-high reset
//   bus      led_matrix_scan_ctrl_if.slave (row serial in, buttons, status)
//   col_out  open-drain column drive: selected column is z, others 0
// Build option: define LED_MATRIX_GHOST_BLANK_EN to drive every column low
// for the first BLANK cycles of each dwell period.
// ---------------------------------------------------------------------------
module led_matrix_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int DWELL    = 256,
    parameter int DEBOUNCE = 1024,
    parameter int BLANK    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    led_matrix_scan_ctrl_if.slave   bus,
    output wire  [COLS-1:0]         col_out
);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(DWELL);
    localparam int BW = $clog2(DEBOUNCE);

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE - 1);
    localparam logic [DW-1:0] BLANK_CNT  = DW'(BLANK);
`ifdef LED_MATRIX_GHOST_BLANK_EN
    localparam logic BLANK_EN = 1'b1;
`else
    localparam logic BLANK_EN = 1'b0;
`endif

    // ---------------- synchronisers ----------------
    logic             w_row_clk_s;
    logic             w_row_data_s;
    logic             w_row_latch_s;
    logic [BTN_N-1:0] w_btn_s;

    sync2 #(.RST_VAL(1'b0)) u_sync_row_clk   (.clk(clk), .rst(rst), .i_d(bus.row_clk),   .o_q(w_row_clk_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_row_data  (.clk(clk), .rst(rst), .i_d(bus.row_data),  .o_q(w_row_data_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_row_latch (.clk(clk), .rst(rst), .i_d(bus.row_latch), .o_q(w_row_latch_s));

    // Button pads idle high, so their synchronisers reset to 1 to avoid a
    // spurious "all pressed" sample straight after reset.
    generate
        for (genvar gi = 0; gi < BTN_N; gi++) begin : g_btn_sync
            sync2 #(.RST_VAL(1'b1)) u_sync_btn (.clk(clk), .rst(rst), .i_d(bus.btn_n[gi]), .o_q(w_btn_s[gi]));
        end
    endgenerate

    // ---------------- row path and column scan ----------------
    logic            r_row_clk_d;
    logic            r_row_latch_d;
    logic [ROWS-1:0] r_shift;
    logic [ROWS-1:0] r_row_out;
    logic            r_armed;
    logic [DW-1:0]   r_dwell;
    logic [CW-1:0]   r_col;
    logic            r_col_adv;

    logic w_row_clk_rise;
    logic w_latch_rise;
    logic w_adv;
    logic w_blank;

    assign w_row_clk_rise = w_row_clk_s & ~r_row_clk_d;
    assign w_latch_rise   = w_row_latch_s & ~r_row_latch_d;
    assign w_adv          = (r_dwell == DWELL_LAST);
    assign w_blank        = BLANK_EN && (r_dwell < BLANK_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_clk_d   <= 1'b0;
            r_row_latch_d <= 1'b0;
            r_shift       <= '0;
            r_row_out     <= '0;
            r_armed       <= 1'b0;
            r_dwell       <= '0;
            r_col         <= '0;
            r_col_adv     <= 1'b0;
        end else begin
            r_row_clk_d   <= w_row_clk_s;
            r_row_latch_d <= w_row_latch_s;
            if (w_row_clk_rise)
                r_shift <= {r_shift[ROWS-2:0], w_row_data_s};

            if (w_adv) begin
                r_dwell <= '0;
                r_col   <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
            r_col_adv <= w_adv;

            // Transfer reads r_shift before any same-cycle shift; a latch
            // seen in the advance cycle re-arms for the next advance.
            if (w_adv && r_armed) begin
                r_row_out <= r_shift;
                r_armed   <= 1'b0;
            end
            if (w_latch_rise)
                r_armed <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col_drv
            assign col_out[gi] = ((r_col == CW'(gi)) && !w_blank) ? 1'bz : 1'b0;
        end
    endgenerate

    // ---------------- button debounce and chord encode ----------------
    logic [BTN_N-1:0] r_btn_cand;
    logic [BTN_N-1:0] r_btn_stable;
    logic [BW-1:0]    r_db_cnt;
    btn_code_t        r_btn_code;
    logic             r_btn_valid;
    logic             w_chord_ok;
    btn_code_t        w_chord_code;

    always_comb begin
        w_chord_ok   = 1'b0;
        w_chord_code = '0;
        chord_encode(r_btn_cand, w_chord_ok, w_chord_code);
    end

    // The candidate follows the synchronised pads; any change restarts the
    // count. The counter saturates at DB_LAST so a held value is promoted once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_cand   <= '1;
            r_btn_stable <= '1;
            r_db_cnt     <= '0;
            r_btn_code   <= '0;
            r_btn_valid  <= 1'b0;
        end else begin
            r_btn_valid <= 1'b0;
            if (w_btn_s != r_btn_cand) begin
                r_btn_cand <= w_btn_s;
                r_db_cnt   <= '0;
            end else if (r_db_cnt != DB_LAST) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end else if (r_btn_cand != r_btn_stable) begin
                r_btn_stable <= r_btn_cand;
                if (w_chord_ok) begin
                    r_btn_code  <= w_chord_code;
                    r_btn_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.row_out   = r_row_out;
    assign bus.col_idx   = r_col;
    assign bus.col_adv   = r_col_adv;
    assign bus.btn_code  = r_btn_code;
    assign bus.btn_valid = r_btn_valid;
endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_matrix_scan_ctrl
// Randomised self-checking bench for led_matrix_scan_ctrl. The reference
// model works from elapsed cycles since reset, a table of legal chords and
// the last latched row word.
// ---------------------------------------------------------------------------
module tb_led_matrix_scan_ctrl;
    localparam int ROWS     = 16;
    localparam int COLS     = 16;
    localparam int DWELL    = 256;
    localparam int DEBOUNCE = 1024;
    localparam int BLANK    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wire  [COLS-1:0] col_out;

    int n_total = 0;
    int n_bad   = 0;
    int n_cyc   = 0;
    bit mon_en  = 1'b0;

    // model state
    logic [ROWS-1:0] m_row   = '0;
    logic [4:0]      m_stable = 5'b11111;
    logic [2:0]      m_code  = 3'd0;
    logic [4:0]      chord_tbl [8] = '{5'b11111, 5'b11100, 5'b11010, 5'b10110,
                                       5'b11001, 5'b10101, 5'b10011, 5'b01111};

    led_matrix_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    led_matrix_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .DEBOUNCE(DEBOUNCE), .BLANK(BLANK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .col_out (col_out)
    );

    // External pull-ups: a released column reads 1.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_pu
            pullup pu_i (col_out[gi]);
        end
    endgenerate

    always #5 clk = ~clk;

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: time limit reached, got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h required=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // cycles elapsed since the last reset edge
    always @(posedge clk) begin
        if (rst) n_cyc <= 0;
        else     n_cyc <= n_cyc + 1;
    end

    // scan model: column and blank phase follow directly from elapsed cycles
    always @(negedge clk) begin
        if (mon_en) begin
            int idx;
            bit blank;
            idx   = (n_cyc / DWELL) % COLS;
            blank = 1'b0;
`ifdef LED_MATRIX_GHOST_BLANK_EN
            blank = (n_cyc % DWELL) < BLANK;
`endif
            chk("col_idx", 32'(bus.col_idx), idx);
            chk("col_adv", 32'(bus.col_adv), ((n_cyc > 0) && (n_cyc % DWELL == 0)) ? 1 : 0);
            chk("col_out", 32'(col_out), blank ? 0 : (32'd1 << idx));
        end
    end

    task automatic tick(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_adv();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.col_adv && k < 2 * DWELL);
        chk("adv_seen", 32'(bus.col_adv), 1);
    endtask

    task automatic shift_bit(input logic b);
        bus.row_data = b;
        tick(3);
        bus.row_clk = 1'b1;
        tick(4);
        bus.row_clk = 1'b0;
        tick(3);
    endtask

    task automatic do_latch();
        bus.row_latch = 1'b1;
        tick(3);
        bus.row_latch = 1'b0;
        tick(3);
    endtask

    // Shift a full word MSB first (so the register ends up equal to data),
    // optionally latch, and check row_out around the next advance.
    task automatic do_row(input logic [ROWS-1:0] data, input bit latch);
        wait_adv();
        tick(1);
        for (int i = ROWS - 1; i >= 0; i--) shift_bit(data[i]);
        if (latch) do_latch();
        chk("row_before_adv", 32'(bus.row_out), 32'(m_row));
        wait_adv();
        if (latch) m_row = data;
        #1;
        chk("row_after_adv", 32'(bus.row_out), 32'(m_row));
        $display("row data=%h latch=%0d row_out=%h", data, latch, bus.row_out);
    endtask

    task automatic do_btn(input logic [4:0] pat);
        int pulses = 0;
        int first_k = -1;
        bit ok = 1'b0;
        int idx = 0;
        bit exp_p;
        for (int j = 0; j < 8; j++)
            if (chord_tbl[j] == pat) begin
                ok  = 1'b1;
                idx = j;
            end
        tick(1);
        bus.btn_n = pat;
        for (int k = 1; k <= DEBOUNCE + 5; k++) begin
            tick(1);
            if (bus.btn_valid) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        exp_p = (pat != m_stable) && ok;
        if (exp_p) m_code = 3'(idx);
        m_stable = pat;
        chk("btn_pulses", pulses, exp_p ? 1 : 0);
        if (exp_p) chk("btn_latency", first_k, DEBOUNCE + 3);
        chk("btn_code", 32'(bus.btn_code), 32'(m_code));
        $display("btn pattern=%b pulses=%0d code=%0d", pat, pulses, bus.btn_code);
    endtask

    initial begin
        logic [ROWS-1:0] rdata;
        logic [4:0]      pat;
        int              pulses;

        bus.row_clk   = 1'b0;
        bus.row_data  = 1'b0;
        bus.row_latch = 1'b0;
        bus.btn_n     = 5'b11111;
        tick(3);
        rst    = 1'b0;
        mon_en = 1'b1;
        chk("rst_row_out",   32'(bus.row_out),   0);
        chk("rst_col_idx",   32'(bus.col_idx),   0);
        chk("rst_btn_code",  32'(bus.btn_code),  0);
        chk("rst_btn_valid", 32'(bus.btn_valid), 0);

        // 1,0,1,0,0,1,1 followed by 9 zeros: 16 shifts put the first bit at
        // bit 15, giving 16'hA600.
        do_row(16'hA600, 1'b1);
        wait_adv();
        #1;
        chk("row_hold", 32'(bus.row_out), 32'(m_row));
        $display("row hold row_out=%h", bus.row_out);

        for (int i = 0; i < 4; i++) begin
            rdata = ROWS'($urandom);
            if (i == 3) do_row(rdata | 16'h0001, 1'b1);
            else        do_row(rdata, bit'($urandom_range(0, 1)));
        end

        // every chord in turn, ending on code 0
        for (int c = 1; c <= 8; c++) do_btn(chord_tbl[c % 8]);

        // bouncing pad never settles
        pulses = 0;
        for (int t = 0; t < 8; t++) begin
            bus.btn_n = bus.btn_n ^ 5'b00001;
            for (int k = 0; k < DEBOUNCE / 2; k++) begin
                tick(1);
                if (bus.btn_valid) pulses++;
            end
        end
        chk("toggle_pulses", pulses, 0);
        chk("toggle_code", 32'(bus.btn_code), 32'(m_code));
        $display("btn toggle pulses=%0d code=%0d", pulses, bus.btn_code);

        do_btn(5'b11000);

        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 1) == 1) pat = chord_tbl[$urandom_range(0, 7)];
            else                           pat = 5'($urandom_range(0, 31));
            do_btn(pat);
        end
        do_btn(5'b10101);

        // reset in the middle of a dwell period with a partial row shifted in
        wait_adv();
        tick($urandom_range(20, 100));
        for (int i = 0; i < 3; i++) shift_bit(1'b1);
        rst       = 1'b1;
        bus.btn_n = 5'b11111;
        tick(1);
        rst = 1'b0;
        m_row    = '0;
        m_stable = 5'b11111;
        m_code   = 3'd0;
        chk("mid_rst_row_out",   32'(bus.row_out),   0);
        chk("mid_rst_col_idx",   32'(bus.col_idx),   0);
        chk("mid_rst_col_adv",   32'(bus.col_adv),   0);
        chk("mid_rst_btn_code",  32'(bus.btn_code),  0);
        chk("mid_rst_btn_valid", 32'(bus.btn_valid), 0);
        do_latch();
        wait_adv();
        #1;
        chk("rst_latch_row", 32'(bus.row_out), 0);
        $display("reset latch row_out=%h", bus.row_out);

        tick(2);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
